// File: rtl/crop_down_pool.sv
// crop_down_pool: crops an X_INIT..X_MAX x Y_INIT..Y_MAX window from a raster pixel stream (iCLK, async active-low iRST, sync buf_rst, iDVAL/iX/iY/iDATA) and emits one pixel per SXxSY box on oDATA/oDVAL/oCOL/oROW/oFRAME_DONE; box-average pooling when CROP_DOWN_POOL_AVG_EN is defined, top-left point sampling otherwise
module crop_down_pool #(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 8,
  parameter int X_INIT   = 27,
  parameter int Y_INIT   = 17,
  parameter int SX       = 21,
  parameter int SY       = 16,
  parameter int OUT_COLS = 28,
  parameter int OUT_ROWS = 28
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iDVAL,
  input  logic                        buf_rst,
  input  logic [9:0]                  iX,
  input  logic [9:0]                  iY,
  input  logic [IN_W-1:0]             iDATA,
  output logic [OUT_W-1:0]            oDATA,
  output logic                        oDVAL,
  output logic [$clog2(OUT_COLS)-1:0] oCOL,
  output logic [$clog2(OUT_ROWS)-1:0] oROW,
  output logic                        oFRAME_DONE
);
  localparam int CW = $clog2(OUT_COLS);
  localparam int RW = $clog2(OUT_ROWS);
  localparam int PXW = SX > 1 ? $clog2(SX) : 1;
  localparam int PYW = SY > 1 ? $clog2(SY) : 1;
  localparam logic [9:0] XI = 10'(X_INIT);
  localparam logic [9:0] XM = 10'(X_INIT + SX * OUT_COLS - 1);
  localparam logic [9:0] YI = 10'(Y_INIT);
  localparam logic [9:0] YM = 10'(Y_INIT + SY * OUT_ROWS - 1);
  localparam logic [PXW-1:0] PX_L = PXW'(SX - 1);
  localparam logic [PYW-1:0] PY_L = PYW'(SY - 1);
  localparam logic [CW-1:0] CX_L = CW'(OUT_COLS - 1);
  localparam logic [RW-1:0] RY_L = RW'(OUT_ROWS - 1);
`ifdef CROP_DOWN_POOL_AVG_EN
  localparam int SUM_W = IN_W + $clog2(SX * SY);
  localparam logic [16:0] RECIP = 17'((65536 + SX * SY - 1) / (SX * SY));
`endif
  logic run_q, run_d, take, at_x0, at_org, at_xm, px_end, py_end, first;
  logic [PXW-1:0] px_q, px_d, px_e;
  logic [PYW-1:0] py_q, py_d, py_e;
  logic [CW-1:0] cx_q, cx_d, cx_e, o_col_q, o_col_d;
  logic [RW-1:0] ry_q, ry_d, ry_e, o_row_q, o_row_d;
  logic [OUT_W-1:0] o_data_q, o_data_d;
  logic o_dval_q, o_dval_d, o_fd_q, o_fd_d;
`ifdef CROP_DOWN_POOL_AVG_EN
  logic [SUM_W-1:0] acc_q [OUT_COLS];
  logic [SUM_W-1:0] acc_d [OUT_COLS];
  logic [SUM_W-1:0] sum, s2_sum_q, s2_sum_d;
  logic [SUM_W:0] avg;
  logic s2_v_q, s2_v_d;
  logic [CW-1:0] s2_col_q, s2_col_d;
  logic [RW-1:0] s2_row_q, s2_row_d;
`endif
  always_comb begin
    at_x0 = iX == XI;
    at_org = at_x0 && iY == YI;
    at_xm = iX == XM;
    take = iDVAL && iX >= XI && iX <= XM && iY >= YI && iY <= YM && !buf_rst && (run_q || at_org);
    run_d = !buf_rst && (run_q || (iDVAL && at_org));
    px_e = at_x0 ? '0 : px_q;
    cx_e = at_x0 ? '0 : cx_q;
    py_e = at_org ? '0 : py_q;
    ry_e = at_org ? '0 : ry_q;
    px_end = px_e == PX_L;
    py_end = py_e == PY_L;
    first = px_e == '0 && py_e == '0;
    px_d = buf_rst ? '0 : !take ? px_q : px_end ? '0 : px_e + PXW'(1);
    cx_d = buf_rst ? '0 : !take ? cx_q : !px_end ? cx_e : cx_e == CX_L ? '0 : cx_e + CW'(1);
    py_d = buf_rst ? '0 : !take ? py_q : !at_xm ? py_e : py_end ? '0 : py_e + PYW'(1);
    ry_d = buf_rst ? '0 : !take ? ry_q : !(at_xm && py_end) ? ry_e : ry_e == RY_L ? '0 : ry_e + RW'(1);
`ifdef CROP_DOWN_POOL_AVG_EN
    sum = first ? SUM_W'(iDATA) : acc_q[cx_e] + SUM_W'(iDATA);
    for (int i = 0; i < OUT_COLS; i++) acc_d[i] = buf_rst ? '0 : take && cx_e == CW'(i) ? sum : acc_q[i];
    s2_v_d = take && px_end && py_end;
    s2_sum_d = s2_v_d ? sum : s2_sum_q;
    s2_col_d = s2_v_d ? cx_e : s2_col_q;
    s2_row_d = s2_v_d ? ry_e : s2_row_q;
    avg = (SUM_W+1)'(((SUM_W+17)'(s2_sum_q) * (SUM_W+17)'(RECIP)) >> 16);
    o_dval_d = s2_v_q && !buf_rst;
    o_data_d = !o_dval_d ? o_data_q : |(avg >> IN_W) ? '1 : OUT_W'(avg >> (IN_W - OUT_W));
    o_col_d = o_dval_d ? s2_col_q : o_col_q;
    o_row_d = o_dval_d ? s2_row_q : o_row_q;
`else
    o_dval_d = take && first;
    o_data_d = o_dval_d ? OUT_W'(iDATA >> (IN_W - OUT_W)) : o_data_q;
    o_col_d = o_dval_d ? cx_e : o_col_q;
    o_row_d = o_dval_d ? ry_e : o_row_q;
`endif
    o_fd_d = o_dval_d && o_col_d == CX_L && o_row_d == RY_L;
  end
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run_q <= 1'b0;
      px_q <= '0;
      cx_q <= '0;
      py_q <= '0;
      ry_q <= '0;
      o_data_q <= '0;
      o_dval_q <= 1'b0;
      o_col_q <= '0;
      o_row_q <= '0;
      o_fd_q <= 1'b0;
`ifdef CROP_DOWN_POOL_AVG_EN
      acc_q <= '{default: '0};
      s2_v_q <= 1'b0;
      s2_sum_q <= '0;
      s2_col_q <= '0;
      s2_row_q <= '0;
`endif
    end else begin
      run_q <= run_d;
      px_q <= px_d;
      cx_q <= cx_d;
      py_q <= py_d;
      ry_q <= ry_d;
      o_data_q <= o_data_d;
      o_dval_q <= o_dval_d;
      o_col_q <= o_col_d;
      o_row_q <= o_row_d;
      o_fd_q <= o_fd_d;
`ifdef CROP_DOWN_POOL_AVG_EN
      acc_q <= acc_d;
      s2_v_q <= s2_v_d;
      s2_sum_q <= s2_sum_d;
      s2_col_q <= s2_col_d;
      s2_row_q <= s2_row_d;
`endif
    end
  end
  assign oDATA = o_data_q;
  assign oDVAL = o_dval_q;
  assign oCOL = o_col_q;
  assign oROW = o_row_q;
  assign oFRAME_DONE = o_fd_q;
endmodule

// File: tb/tb_crop_down_pool.sv
// tb_crop_down_pool: scoreboard bench for crop_down_pool on a reduced 32x12 raster with a 3x3 grid of 9x3 boxes
module tb_crop_down_pool;
  localparam int XI = 2, YI = 1, SX = 9, SY = 3, NC = 3, NR = 3;
  localparam int XM = XI + SX * NC - 1, YM = YI + SY * NR - 1;
  localparam int W = 32, H = 12;
  localparam longint RECIP = 2428;
`ifdef CROP_DOWN_POOL_AVG_EN
  localparam int LAT = 2;
  localparam int N_TOT = 57;
`else
  localparam int LAT = 1;
  localparam int N_TOT = 63;
`endif
  typedef struct {
    logic [7:0] d;
    int c;
    int r;
    logic fd;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic iRST, iDVAL, buf_rst;
  logic [9:0] iX, iY;
  logic [11:0] iDATA;
  logic [7:0] oDATA;
  logic oDVAL, oFRAME_DONE;
  logic [1:0] oCOL, oROW;
  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0, cyc = 0, n_out = 0;
  int sum_m [NC][NR];
  logic [7:0] last_d;
  logic [1:0] last_c, last_r;
  crop_down_pool #(
    .IN_W(12), .OUT_W(8), .X_INIT(XI), .Y_INIT(YI), .SX(SX), .SY(SY), .OUT_COLS(NC), .OUT_ROWS(NR)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iDVAL(iDVAL), .buf_rst(buf_rst), .iX(iX), .iY(iY), .iDATA(iDATA),
    .oDATA(oDATA), .oDVAL(oDVAL), .oCOL(oCOL), .oROW(oROW), .oFRAME_DONE(oFRAME_DONE)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  function automatic logic [7:0] avg_of(input int s);
    longint a;
    logic [11:0] v;
    a = (longint'(s) * RECIP) >> 16;
    v = a > 4095 ? 12'hFFF : 12'(a);
    return v[11:4];
  endfunction
  task automatic check_zero();
    chk("rst_data", oDATA, 0);
    chk("rst_dval", oDVAL, 0);
    chk("rst_col", oCOL, 0);
    chk("rst_row", oROW, 0);
    chk("rst_frame_done", oFRAME_DONE, 0);
  endtask
  task automatic step(input int x, input int y, input logic [11:0] d, input logic dv, input logic br);
    int c, r, px, py;
    exp_t e;
    @(posedge clk);
    #1;
    iX = 10'(x);
    iY = 10'(y);
    iDATA = d;
    iDVAL = dv;
    buf_rst = br;
    if (dv && !br && x >= XI && x <= XM && y >= YI && y <= YM) begin
      c = (x - XI) / SX;
      px = (x - XI) % SX;
      r = (y - YI) / SY;
      py = (y - YI) % SY;
      sum_m[c][r] = (px == 0 && py == 0) ? int'(d) : sum_m[c][r] + int'(d);
      e.c = c;
      e.r = r;
      e.fd = c == NC - 1 && r == NR - 1;
      e.cyc = cyc + LAT;
`ifdef CROP_DOWN_POOL_AVG_EN
      if (px == SX - 1 && py == SY - 1) begin
        e.d = avg_of(sum_m[c][r]);
        q.push_back(e);
      end
`else
      if (px == 0 && py == 0) begin
        e.d = d[11:4];
        q.push_back(e);
      end
`endif
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 12'h0, 1'b0, 1'b0);
  endtask
  task automatic frame(input logic pat, input logic [11:0] k, input int kind, input int ax, input int ay);
    logic [11:0] d;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        d = pat ? 12'({6'(x), 6'(y)}) : k;
        if (kind != 0 && x == ax && y == ay) begin
          if (kind == 1) begin
            step(x, y, d, 1'b1, 1'b1);
            idle(4);
            chk("brst_queue_empty", q.size(), 0);
          end else begin
            step(x, y, d, 1'b1, 1'b0);
            iRST = 1'b0;
            chk("rst_queue_empty", q.size(), 0);
            q.delete();
            repeat (3) begin
              @(negedge clk);
              check_zero();
            end
            @(posedge clk);
            #1 iRST = 1'b1;
            idle(3);
          end
          return;
        end
        step(x, y, d, 1'b1, 1'b0);
      end
      repeat (2) step(int'(W + $urandom_range(0, 20)), y, 12'hFFF, 1'b0, 1'b0);
    end
    idle(4);
  endtask
  always @(negedge clk) begin
    if (!iRST) begin
      last_d = '0;
      last_c = '0;
      last_r = '0;
    end else if (oDVAL) begin
      n_out++;
      chk("dval_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("data", oDATA, me.d);
        chk("col", oCOL, me.c);
        chk("row", oROW, me.r);
        chk("frame_done", oFRAME_DONE, me.fd);
        chk("latency", cyc, me.cyc);
      end
      last_d = oDATA;
      last_c = oCOL;
      last_r = oROW;
    end else begin
      chk("hold_data", oDATA, last_d);
      chk("hold_col", oCOL, last_c);
      chk("hold_row", oROW, last_r);
      chk("frame_done_idle", oFRAME_DONE, 0);
    end
  end
  initial begin
    iRST = 1'b0;
    iDVAL = 1'b0;
    buf_rst = 1'b0;
    iX = '0;
    iY = '0;
    iDATA = '0;
    repeat (3) begin
      @(negedge clk);
      check_zero();
    end
    @(posedge clk);
    #1 iRST = 1'b1;
    idle(5);
    frame(1'b0, 12'hABC, 0, 0, 0);
    frame(1'b0, 12'hFFF, 0, 0, 0);
    frame(1'b0, 12'h000, 0, 0, 0);
    frame(1'b1, 12'h000, 0, 0, 0);
    frame(1'b1, 12'h000, 1, 10, 2);
    frame(1'b1, 12'h000, 0, 0, 0);
    frame(1'b0, 12'h123, 2, 15, 5);
    frame(1'b1, 12'h000, 0, 0, 0);
    idle(6);
    chk("final_queue_empty", q.size(), 0);
    chk("outputs_total", n_out, N_TOT);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
